// File: rtl/drv8320_update_sched.sv
// Avalon-MM master that initialises the 4-servo DRV8320 PWM core and, on every
// measurement trigger, pushes the pending duty commands and commits them via TR.U_VALID.
module drv8320_update_sched #(
  parameter int unsigned PWM_PRES    = 9,
  parameter int unsigned PWM_HPERIOD = 4999,
  parameter logic [3:0]  DRV_EN_MASK = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        trig,
  input  logic [3:0]  cmd_valid,
  input  logic [63:0] cmd_duty,
  output logic [5:0]  av_address,
  output logic [31:0] av_writedata,
  output logic        av_write_n,
  input  logic        av_waitrequest,
  output logic        busy,
  output logic        running,
  output logic        overrun,
  output logic [7:0]  overrun_cnt,
  input  logic        clr_overrun
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned UW = 16;
  localparam int unsigned CW = 8;

  localparam logic [AW-1:0] ADDR_CR   = AW'(0);
  localparam logic [AW-1:0] ADDR_TR   = AW'(1);
  localparam logic [AW-1:0] ADDR_PRES = AW'(5);
  localparam logic [AW-1:0] ADDR_HP   = AW'(6);
  localparam logic [AW-1:0] ADDR_U0   = AW'(11);

  localparam logic [DW-1:0] CR_START  = DW'({DRV_EN_MASK, 9'h001});
  localparam logic [DW-1:0] TR_UVALID = DW'(1);

  typedef enum logic [2:0] {
    IDLE,
    INIT_PRES,
    INIT_HP,
    INIT_CR,
    WAIT_TRIG,
    WR_U,
    WR_TR,
    STOP
  } state_t;

  state_t state, state_n;
  logic [1:0] idx, idx_n;

  logic [NS-1:0][UW-1:0] shadow;
  logic [NS-1:0][UW-1:0] work;
  logic [NS-1:0]         pend;
  logic [NS-1:0]         wpend;

  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_n;
  logic          write_n_n;
  logic          snap_c;
  logic          can_step;
  logic          ov_evt;

  // A slot may advance when no write is in flight or the in-flight one completes now.
  assign can_step = av_write_n | ~av_waitrequest;
  assign ov_evt   = trig & ((state == WR_U) | (state == WR_TR));

  // Next-state and next bus-cycle decode; bus outputs are registered from these.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    snap_c    = 1'b0;
    addr_n    = av_address;
    data_n    = av_writedata;
    write_n_n = can_step;

    case (state)
      IDLE: begin
        if (enable) begin
          state_n   = INIT_PRES;
          addr_n    = ADDR_PRES;
          data_n    = DW'(PWM_PRES);
          write_n_n = 1'b0;
        end
      end
      INIT_PRES: begin
        if (can_step) begin
          state_n   = INIT_HP;
          addr_n    = ADDR_HP;
          data_n    = DW'(PWM_HPERIOD);
          write_n_n = 1'b0;
        end
      end
      INIT_HP: begin
        if (can_step) begin
          state_n   = INIT_CR;
          addr_n    = ADDR_CR;
          data_n    = CR_START;
          write_n_n = 1'b0;
        end
      end
      INIT_CR: begin
        if (can_step) state_n = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (trig) begin
          snap_c  = 1'b1;
          state_n = WR_U;
          idx_n   = 2'd0;
          if (pend[0]) begin
            addr_n    = ADDR_U0;
            data_n    = {16'h0, shadow[0]};
            write_n_n = 1'b0;
          end
        end
      end
      WR_U: begin
        if (can_step) begin
          if (idx == 2'd3) begin
            state_n   = WR_TR;
            addr_n    = ADDR_TR;
            data_n    = TR_UVALID;
            write_n_n = 1'b0;
          end else begin
            idx_n = idx + 2'd1;
            if (wpend[idx_n]) begin
              addr_n    = ADDR_U0 + AW'(idx_n);
              data_n    = {16'h0, work[idx_n]};
              write_n_n = 1'b0;
            end
          end
        end
      end
      WR_TR: begin
        if (can_step) state_n = WAIT_TRIG;
      end
      STOP: begin
        if (can_step) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Dropping enable abandons the sequence once any in-flight write has completed.
    if (!enable && can_step &&
        (state inside {INIT_PRES, INIT_HP, INIT_CR, WAIT_TRIG, WR_U, WR_TR})) begin
      state_n   = STOP;
      idx_n     = idx;
      snap_c    = 1'b0;
      addr_n    = ADDR_CR;
      data_n    = '0;
      write_n_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= 2'd0;
      av_address   <= '0;
      av_writedata <= '0;
      av_write_n   <= 1'b1;
      busy         <= 1'b0;
      running      <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      av_address   <= addr_n;
      av_writedata <= data_n;
      av_write_n   <= write_n_n;
      busy         <= !((state_n == IDLE) || (state_n == WAIT_TRIG));
      running      <= (state_n inside {WAIT_TRIG, WR_U, WR_TR});
    end
  end

  // Command shadows; a strobe coinciding with a snapshot lands in the next period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      work   <= '0;
      pend   <= '0;
      wpend  <= '0;
    end else begin
      if (snap_c) begin
        work  <= shadow;
        wpend <= pend;
      end
      for (int i = 0; i < NS; i++) begin
        if (cmd_valid[i]) shadow[i] <= cmd_duty[UW*i +: UW];
      end
      pend <= (snap_c ? '0 : pend) | cmd_valid;
    end
  end

  // Sticky overrun flag and saturating counter; clear takes priority over a new event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else if (clr_overrun) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else if (ov_evt) begin
      overrun <= 1'b1;
      if (overrun_cnt != {CW{1'b1}}) overrun_cnt <= overrun_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_drv8320_update_sched.sv
// Directed bench for drv8320_update_sched: logs completed bus writes and checks them
// against hand-computed sequences, latencies, stall behaviour and overrun counting.
module tb_drv8320_update_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        trig;
  logic [3:0]  cmd_valid;
  logic [63:0] cmd_duty;
  logic [5:0]  av_address;
  logic [31:0] av_writedata;
  logic        av_write_n;
  logic        av_waitrequest;
  logic        busy;
  logic        running;
  logic        overrun;
  logic [7:0]  overrun_cnt;
  logic        clr_overrun;

  drv8320_update_sched dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .trig           (trig),
    .cmd_valid      (cmd_valid),
    .cmd_duty       (cmd_duty),
    .av_address     (av_address),
    .av_writedata   (av_writedata),
    .av_write_n     (av_write_n),
    .av_waitrequest (av_waitrequest),
    .busy           (busy),
    .running        (running),
    .overrun        (overrun),
    .overrun_cnt    (overrun_cnt),
    .clr_overrun    (clr_overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Completed-write log; entry edge is the rising edge on which the write completes.
  logic [5:0]  log_a [64];
  logic [31:0] log_d [64];
  int unsigned log_e [64];
  int          n_log = 0;

  always @(negedge clk) begin
    if (reset_n && !av_write_n && !av_waitrequest) begin
      if (n_log < 64) begin
        log_a[n_log] <= av_address;
        log_d[n_log] <= av_writedata;
        log_e[n_log] <= cyc + 1;
      end
      n_log <= n_log + 1;
    end
  end

  int tot = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [5:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, 32'(log_a[i]), 32'(a));
    chk({tag, "_data"}, log_d[i], d);
  endtask

  // Wait (bounded) for WAIT_TRIG (want_run=1) or IDLE (want_run=0) with the bus quiet.
  task automatic wait_state(input string tag, input bit want_run);
    int k = 0;
    while (!(av_write_n && !busy && (running == want_run)) && k < 60) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < 60), 32'd1);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] m, input logic [63:0] d);
    cmd_valid = m;
    cmd_duty  = d;
    tick();
    cmd_valid = '0;
  endtask

  int base;
  int unsigned te;

  initial begin
    reset_n = 1'b0; enable = 1'b0; trig = 1'b0; cmd_valid = '0; cmd_duty = '0;
    av_waitrequest = 1'b0; clr_overrun = 1'b0;
    tick(2);
    chk("rst_write_n", 32'(av_write_n), 32'd1);
    chk("rst_addr", 32'(av_address), 32'd0);
    chk("rst_data", av_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_cnt", 32'(overrun_cnt), 32'd0);
    reset_n = 1'b1;
    tick();

    // Init sequence on three consecutive edges
    base = n_log;
    enable = 1'b1;
    tick();
    wait_state("init_wait", 1'b1);
    chk("init_count", 32'(n_log - base), 32'd3);
    chk_wr("init0", base, 6'd5, 32'd9);
    chk_wr("init1", base + 1, 6'd6, 32'd4999);
    chk_wr("init2", base + 2, 6'd0, 32'h1E01);
    chk("init_gap1", log_e[base + 1] - log_e[base], 32'd1);
    chk("init_gap2", log_e[base + 2] - log_e[base + 1], 32'd1);

    // Servo 0 and 2 pending
    strobe(4'b0101, {16'h0000, 16'h8000, 16'h0000, 16'h1234});
    base = n_log;
    pulse_trig();
    wait_state("u02_wait", 1'b1);
    chk("u02_count", 32'(n_log - base), 32'd3);
    chk_wr("u02_0", base, 6'd11, 32'h1234);
    chk_wr("u02_1", base + 1, 6'd13, 32'h8000);
    chk_wr("u02_2", base + 2, 6'd1, 32'h1);

    // No pending servo: TR only, twice (pending stays clear)
    for (int r = 0; r < 2; r++) begin
      base = n_log;
      pulse_trig();
      wait_state("tr_only_wait", 1'b1);
      chk("tr_only_count", 32'(n_log - base), 32'd1);
      chk_wr("tr_only", base, 6'd1, 32'h1);
    end

    // All four pending: latency from the trig edge
    strobe(4'hF, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    base = n_log;
    trig = 1'b1;
    te = cyc + 1;
    tick();
    trig = 1'b0;
    wait_state("all4_wait", 1'b1);
    chk("all4_count", 32'(n_log - base), 32'd5);
    chk_wr("all4_u0", base, 6'd11, 32'h1111);
    chk_wr("all4_u1", base + 1, 6'd12, 32'h2222);
    chk_wr("all4_u2", base + 2, 6'd13, 32'h3333);
    chk_wr("all4_u3", base + 3, 6'd14, 32'h4444);
    chk_wr("all4_tr", base + 4, 6'd1, 32'h1);
    chk("lat_first_u", log_e[base] - te, 32'd1);
    chk("lat_tr", log_e[base + 4] - te, 32'd5);

    // Stalled U0 write holds address and data
    strobe(4'b0011, {16'h0000, 16'h0000, 16'h00BB, 16'h00AA});
    base = n_log;
    trig = 1'b1;
    av_waitrequest = 1'b1;
    tick();
    trig = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_write_n", 32'(av_write_n), 32'd0);
      chk("stall_addr", 32'(av_address), 32'd11);
      chk("stall_data", av_writedata, 32'h00AA);
      @(posedge clk);
      #1;
    end
    av_waitrequest = 1'b0;
    wait_state("stall_wait", 1'b1);
    chk("stall_count", 32'(n_log - base), 32'd3);
    chk_wr("stall_u0", base, 6'd11, 32'h00AA);
    chk_wr("stall_u1", base + 1, 6'd12, 32'h00BB);
    chk_wr("stall_tr", base + 2, 6'd1, 32'h1);

    // Overrun while the U0 write is stalled
    strobe(4'b0001, {48'h0, 16'h5555});
    base = n_log;
    av_waitrequest = 1'b1;
    pulse_trig();
    chk("ovr_pre", 32'(overrun), 32'd0);
    pulse_trig();
    chk("ovr_first", 32'(overrun), 32'd1);
    chk("ovr_cnt1", 32'(overrun_cnt), 32'd1);
    trig = 1'b1;
    tick(300);
    trig = 1'b0;
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    trig = 1'b1;
    clr_overrun = 1'b1;
    tick();
    trig = 1'b0;
    clr_overrun = 1'b0;
    chk("clr_overrun", 32'(overrun), 32'd0);
    chk("clr_cnt", 32'(overrun_cnt), 32'd0);
    pulse_trig();
    chk("ovr_after_clr", 32'(overrun_cnt), 32'd1);

    // enable drop with the write still stalled
    enable = 1'b0;
    tick(2);
    chk("stop_hold_wn", 32'(av_write_n), 32'd0);
    chk("stop_hold_addr", 32'(av_address), 32'd11);
    chk("stop_hold_data", av_writedata, 32'h5555);
    av_waitrequest = 1'b0;
    wait_state("stop_wait", 1'b0);
    chk("stop_count", 32'(n_log - base), 32'd2);
    chk_wr("stop_u0", base, 6'd11, 32'h5555);
    chk_wr("stop_cr", base + 1, 6'd0, 32'h0);

    // Restart init, then async reset in the middle of the stalled PRES write
    enable = 1'b1;
    av_waitrequest = 1'b1;
    tick(2);
    chk("restart_wn", 32'(av_write_n), 32'd0);
    chk("restart_addr", 32'(av_address), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_wn", 32'(av_write_n), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_cnt", 32'(overrun_cnt), 32'd0);
    enable = 1'b0;
    av_waitrequest = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(3);
    chk("post_rst_wn", 32'(av_write_n), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
